// File: rtl/capture_rle2_pkg.sv
// Shared definitions for the capture_rle2 sampler: packing modes, per-mode
// sample widths, run-length count limits and word packing.
package capture_rle2_pkg;

   typedef enum logic [1:0] {
      MODE_16_16 = 2'd0,
      MODE_24_8  = 2'd1,
      MODE_RAW   = 2'd2,
      MODE_8_24  = 2'd3
   } mode_e;

   localparam int unsigned SAMPLE_W_16_16 = 16;
   localparam int unsigned SAMPLE_W_24_8  = 24;
   localparam int unsigned SAMPLE_W_RAW   = 32;
   localparam int unsigned SAMPLE_W_8_24  = 8;

   localparam logic [23:0] COUNT_MAX_16_16 = 24'h00FFFF;
   localparam logic [23:0] COUNT_MAX_24_8  = 24'h0000FF;
   localparam logic [23:0] COUNT_MAX_8_24  = 24'hFFFFFF;

   localparam logic [23:0] COUNT_ONE = 24'd1;

   function automatic logic [31:0] sample_mask(input mode_e mode);
      logic [31:0] mask;
      mask = '1;
      case (mode)
         MODE_16_16: mask = 32'h0000_FFFF;
         MODE_24_8:  mask = 32'h00FF_FFFF;
         MODE_8_24:  mask = 32'h0000_00FF;
         default:    mask = '1;
      endcase
      return mask;
   endfunction

   function automatic logic [23:0] count_max(input mode_e mode);
      logic [23:0] cmax;
      cmax = COUNT_MAX_8_24;
      case (mode)
         MODE_16_16: cmax = COUNT_MAX_16_16;
         MODE_24_8:  cmax = COUNT_MAX_24_8;
         default:    cmax = COUNT_MAX_8_24;
      endcase
      return cmax;
   endfunction

   // Count always occupies the MSBs; raw mode carries the sample alone.
   function automatic logic [31:0] pack_word(input mode_e mode,
                                             input logic [23:0] count,
                                             input logic [31:0] sample);
      logic [31:0] word;
      word = sample;
      case (mode)
         MODE_16_16: word = {count[15:0], sample[15:0]};
         MODE_24_8:  word = {count[7:0],  sample[23:0]};
         MODE_8_24:  word = {count[23:0], sample[7:0]};
         default:    word = sample;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/capture_rle2_fifo.sv
// Single-clock output FIFO for capture_rle2: register-array storage, head word
// presented directly, full/empty flags and a drop strobe for rejected writes.
module capture_rle2_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic             dropped
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level;
   logic             pop_ok;
   logic             push_ok;

   assign empty    = (level == '0);
   assign full     = (level == LEVEL_FULL);
   assign rd_valid = !empty;
   assign rd_data  = mem[rd_ptr];

   // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
   assign pop_ok  = rd_en && !empty;
   assign push_ok = wr_en && (!full || pop_ok);
   assign dropped = wr_en && full && !pop_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/capture_rle2.sv
// Logic-analyser capture with run-length encoding into a 32-bit output stream.
// Optional internal test counter source: define CAPTURE_RLE2_TEST_EN.
module capture_rle2
   import capture_rle2_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] input_i,
   input  logic              cfg_enable_i,
   input  logic [7:0]        cfg_clk_div_i,
   input  logic [1:0]        cfg_mode_i,
   input  logic              cfg_test_mode_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [31:0]       data_o,
   output logic              overflow_o
);

   logic [DATA_W-1:0] sync_q1;
   logic [DATA_W-1:0] sync_q2;
   logic [7:0]        div_q;
   logic              en_q;
   logic              tick;
   logic              en_rise;
   logic              en_fall;
   mode_e             mode;
   logic [31:0]       raw_sample;
   logic [31:0]       src_sample;
   logic [31:0]       sample;
   logic [31:0]       prev_q;
   logic [23:0]       count_q;
   logic              prev_valid_q;
   logic              emit_q;
   logic [31:0]       emit_word_q;
   logic              fifo_drop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              overflow_q;

   assign mode       = mode_e'(cfg_mode_i);
   assign tick       = cfg_enable_i && (div_q == '0);
   assign en_rise    = cfg_enable_i && !en_q;
   assign en_fall    = !cfg_enable_i && en_q;
   assign raw_sample = 32'(sync_q2);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= input_i;
         sync_q2 <= sync_q1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q <= '0;
         en_q  <= 1'b0;
      end else begin
         en_q <= cfg_enable_i;
         if (!cfg_enable_i) begin
            div_q <= '0;
         end else if (div_q == '0) begin
            div_q <= cfg_clk_div_i;
         end else begin
            div_q <= div_q - 8'd1;
         end
      end
   end

`ifdef CAPTURE_RLE2_TEST_EN
   logic [31:0] test_cnt_q;
   logic [31:0] test_next;

   // The sample taken on a tick is the post-increment value, so the first is 1.
   assign test_next  = test_cnt_q + 32'd1;
   assign src_sample = cfg_test_mode_i ? test_next : raw_sample;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         test_cnt_q <= '0;
      end else if (tick) begin
         test_cnt_q <= test_next;
      end
   end
`else
   logic unused_test_mode;

   assign unused_test_mode = cfg_test_mode_i;
   assign src_sample       = raw_sample;
`endif

   assign sample = src_sample & sample_mask(mode);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q       <= '0;
         count_q      <= COUNT_ONE;
         prev_valid_q <= 1'b0;
         emit_q       <= 1'b0;
         emit_word_q  <= '0;
      end else begin
         emit_q <= 1'b0;
         if (tick) begin
            if (!prev_valid_q) begin
               prev_q       <= sample;
               count_q      <= COUNT_ONE;
               prev_valid_q <= 1'b1;
            end else if (mode == MODE_RAW) begin
               emit_q      <= 1'b1;
               emit_word_q <= prev_q;
               prev_q      <= sample;
            end else if ((sample == prev_q) && (count_q < count_max(mode))) begin
               count_q <= count_q + COUNT_ONE;
            end else begin
               emit_q      <= 1'b1;
               emit_word_q <= pack_word(mode, count_q, prev_q);
               prev_q      <= sample;
               count_q     <= COUNT_ONE;
            end
         end else if (en_fall && prev_valid_q) begin
            emit_q       <= 1'b1;
            emit_word_q  <= pack_word(mode, count_q, prev_q);
            count_q      <= COUNT_ONE;
            prev_valid_q <= 1'b0;
         end
      end
   end

   capture_rle2_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .wr_en    (emit_q),
      .wr_data  (emit_word_q),
      .rd_en    (ready_i),
      .rd_valid (valid_o),
      .rd_data  (data_o),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .dropped  (fifo_drop)
   );

   // A drop coinciding with a fresh enable still counts against the new capture.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_q <= 1'b0;
      end else if (fifo_drop) begin
         overflow_q <= 1'b1;
      end else if (en_rise) begin
         overflow_q <= 1'b0;
      end
   end

   assign overflow_o = overflow_q;

   logic unused_flags;
   assign unused_flags = fifo_full ^ fifo_empty;

endmodule

// File: doc/capture_rle2.md
CAPTURE_RLE2 -- requirements
Module: capture_rle2

Interface
REQ-001 Parameter DATA_W, 32, number of captured channels (8..32).
REQ-002 Parameter FIFO_DEPTH, 16, output FIFO depth in words (power of 2, >=2).
REQ-003 Port clk_i  input  1  sole clock; sampling, RLE and output all in this domain.
REQ-004 Port rst_i  input  1  asynchronous, active-high reset.
REQ-005 Port input_i  input  DATA_W  raw channel inputs, asynchronous to clk_i.
REQ-006 Port cfg_enable_i  input  1  capture enable.
REQ-007 Port cfg_clk_div_i  input  8  sample tick every (cfg_clk_div_i+1) cycles.
REQ-008 Port cfg_mode_i  input  2  packing mode: 0=16 sample+16 count, 1=24+8, 2=32 raw (no RLE), 3=8+24.
REQ-009 Port cfg_test_mode_i  input  1  select internal counter as sample source.
REQ-010 Port ready_i  input  1  consumer accepts data_o when high with valid_o.
REQ-011 Port valid_o  output  1  FIFO head word available.
REQ-012 Port data_o  output  32  packed word {count, sample}, count in MSBs.
REQ-013 Port overflow_o  output  1  sticky: at least one word dropped because the FIFO was full.

Function
REQ-014 input_i SHALL pass a 2-flop synchroniser; the sample is the second-stage value, zero-extended or truncated to the mode sample width.
REQ-015 Divider SHALL be held at 0 while cfg_enable_i=0; tick = enabled && divider==0; divider reloads cfg_clk_div_i on tick, else decrements.
REQ-016 First tick after enable: load prev=sample, count=1, prev_valid=1; no emission.
REQ-017 Later ticks, modes 0/1/3: sample==prev and count<max -> count+1; otherwise emit {count,prev}, prev=sample, count=1.
REQ-018 Count max SHALL be 0xFFFF / 0xFF / 0xFFFFFF for modes 0/1/3; count never wraps to 0.
REQ-019 Mode 2: every tick after the first SHALL emit prev unpacked (32 bits), then prev=sample.
REQ-020 Enable 1->0 with prev_valid=1 SHALL emit the pending {count,prev} (mode 2: prev) on the next cycle, then clear prev_valid.
REQ-021 Emitted word SHALL be registered and pushed into the FIFO the cycle after the deciding tick; with empty FIFO and ready_i=1, valid_o rises 2 cycles after that tick.
REQ-022 valid/ready: word transfers on cycle with valid_o&&ready_i; data_o stable while valid_o=1 and ready_i=0.
REQ-023 Push with FIFO full SHALL drop the new word, keep stored words intact and set overflow_o; simultaneous push and pop when full SHALL succeed.
REQ-024 overflow_o SHALL clear only on reset or on enable 0->1.
REQ-025 cfg_mode_i/cfg_clk_div_i changes while enabled are unsupported; only sampled behaviour at enable edges is guaranteed.

Reset
REQ-026 rst_i SHALL asynchronously clear synchroniser, divider, prev, prev_valid, count(=1), FIFO pointers, test counter; valid_o=0, data_o=0, overflow_o=0.
REQ-027 Reset mid-run SHALL discard the pending run without emission.

Configuration
REQ-028 Macro CAPTURE_RLE2_TEST_EN defined: 32-bit test counter increments on every tick; cfg_test_mode_i=1 selects it as sample source.
REQ-029 Macro absent: counter logic omitted, cfg_test_mode_i ignored, port retained.

Structure
REQ-030 Package capture_rle2_pkg SHALL hold mode encodings, per-mode sample width and count-max constants.
REQ-031 FIFO SHALL be sub-module capture_rle2_fifo (single-clock, registered head, full/empty flags).

Verification
REQ-032 Mode 0, div=0, 0x1234 held 5 ticks then 0x5678 -> one word 0x00051234.
REQ-033 Mode 1, 0xABCDEF held 300 ticks then disable -> 0xFFABCDEF then 0x2DABCDEF.
REQ-034 div=3 -> ticks exactly every 4 cycles; mode 2 with changing input -> one raw word per tick.
REQ-035 FIFO_DEPTH=4, ready_i=0, 6 runs -> first 4 words held, overflow_o=1; ready_i=1 -> those 4 in order, overflow_o stays 1 until next enable.
REQ-036 rst_i pulse mid-run -> valid_o=0 and overflow_o=0 immediately, no word emitted afterwards.
REQ-037 CAPTURE_RLE2_TEST_EN, test mode, mode 0, div=0 -> words 0x00010001, 0x00010002, ...
